// File: rtl/hazard_ctl_pkg.sv
// hazard_ctl_pkg: shared mips pipeline constants (forward sources, Tuse sentinel, write-destination and PC-source selects)
package hazard_ctl_pkg;
    localparam logic [2:0] FWD_GRF = 3'd0;
    localparam logic [2:0] FWD_E   = 3'd1;
    localparam logic [2:0] FWD_M   = 3'd2;
    localparam logic [2:0] FWD_W   = 3'd3;
    // Widest supported Tuse sentinel; users slice it down to their counter width.
    localparam logic [7:0] TUSE_NONE = 8'hff;
    localparam logic [1:0] WDST_RT = 2'd0;
    localparam logic [1:0] WDST_RD = 2'd1;
    localparam logic [1:0] WDST_RA = 2'd2;
    localparam logic [1:0] PCSRC_SEQ = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_J   = 2'd2;
    localparam logic [1:0] PCSRC_JR  = 2'd3;
endpackage

// File: rtl/hazard_src.sv
// hazard_src: youngest-match hazard and forward-select for one Decode source operand
// Ports: src/tuse  - source register and its Tuse
//        valid/wen/dst/tnew - flattened per-stage entries, slot 0 = stage 1
//        hazard - operand not ready in time; fwd - stage to forward from (0 = GRF)
module hazard_src
    import hazard_ctl_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int REGW   = 5,
    parameter int TW     = 2
) (
    input  logic [REGW-1:0]        src,
    input  logic [TW-1:0]          tuse,
    input  logic [NSTAGE-1:0]      valid,
    input  logic [NSTAGE-1:0]      wen,
    input  logic [NSTAGE*REGW-1:0] dst,
    input  logic [NSTAGE*TW-1:0]   tnew,
    output logic                   hazard,
    output logic [2:0]             fwd
);
    logic          hit;
    logic          used;
    logic [2:0]    sel;
    logic [TW-1:0] sel_tnew;
    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit      = 1'b0;
        sel      = FWD_GRF;
        sel_tnew = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (valid[k] && wen[k] && dst[k*REGW +: REGW] == src && src != '0) begin
                hit      = 1'b1;
                sel      = 3'(k + 1);
                sel_tnew = tnew[k*TW +: TW];
            end
        end
    end
    assign used   = tuse != TUSE_NONE[TW-1:0];
    assign hazard = used && hit && sel_tnew > tuse;
    assign fwd    = (used && hit && sel_tnew == '0) ? sel : FWD_GRF;
endmodule

// File: rtl/hazard_ctl.sv
// hazard_ctl: Tnew/Tuse stall and forwarding controller for a MIPS-style pipeline
// Ports: clk, reset (async, active-high)
//        d_rs/d_rt, d_tuse_rs/d_tuse_rt - Decode sources and their Tuse
//        d_wen/d_wdst/d_tnew - Decode producer info; ext_stall - external stall
//        stall - freeze F/D and bubble stage 1; fwd_rs/fwd_rt - forward source
//        stall_cnt - saturating stalled-cycle count
module hazard_ctl
    import hazard_ctl_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int REGW   = 5,
    parameter int TW     = 2,
    parameter int CNTW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [REGW-1:0] d_rs,
    input  logic [REGW-1:0] d_rt,
    input  logic [TW-1:0]   d_tuse_rs,
    input  logic [TW-1:0]   d_tuse_rt,
    input  logic            d_wen,
    input  logic [REGW-1:0] d_wdst,
    input  logic [TW-1:0]   d_tnew,
    input  logic            ext_stall,
    output logic            stall,
    output logic [2:0]      fwd_rs,
    output logic [2:0]      fwd_rt,
    output logic [CNTW-1:0] stall_cnt
);
    logic [NSTAGE-1:0]      valid;
    logic [NSTAGE-1:0]      wen;
    logic [NSTAGE*REGW-1:0] dst;
    logic [NSTAGE*TW-1:0]   tnew;
    logic [NSTAGE*TW-1:0]   tdec;
    logic                   haz_rs;
    logic                   haz_rt;
    // Each entry's tnew counts down toward 0 as it advances, saturating there.
    always_comb begin
        tdec = '0;
        for (int k = 0; k < NSTAGE; k++)
            tdec[k*TW +: TW] = (tnew[k*TW +: TW] == '0) ? '0 : tnew[k*TW +: TW] - TW'(1);
    end
    hazard_src #(.NSTAGE(NSTAGE), .REGW(REGW), .TW(TW)) u_rs (
        .src(d_rs), .tuse(d_tuse_rs), .valid(valid), .wen(wen), .dst(dst), .tnew(tnew),
        .hazard(haz_rs), .fwd(fwd_rs)
    );
    hazard_src #(.NSTAGE(NSTAGE), .REGW(REGW), .TW(TW)) u_rt (
        .src(d_rt), .tuse(d_tuse_rt), .valid(valid), .wen(wen), .dst(dst), .tnew(tnew),
        .hazard(haz_rt), .fwd(fwd_rt)
    );
    // Entries are cleared asynchronously, so during reset this reduces to ext_stall.
    assign stall = haz_rs | haz_rt | ext_stall;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid     <= '0;
            wen       <= '0;
            dst       <= '0;
            tnew      <= '0;
            stall_cnt <= '0;
        end else begin
            valid[0]          <= !stall;
            wen[0]            <= !stall && d_wen;
            dst[0 +: REGW]    <= stall ? '0 : d_wdst;
            tnew[0 +: TW]     <= stall ? '0 : d_tnew;
            for (int k = 1; k < NSTAGE; k++) begin
                valid[k]           <= valid[k-1];
                wen[k]             <= wen[k-1];
                dst[k*REGW +: REGW] <= dst[(k-1)*REGW +: REGW];
                tnew[k*TW +: TW]   <= tdec[(k-1)*TW +: TW];
            end
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNTW'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctl.sv
// tb_hazard_ctl: randomized and directed checks of hazard_ctl against an in-bench pipeline model
module tb_hazard_ctl;
    localparam int NST  = 3;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;
    localparam int NONE = 3;
    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [4:0]      d_rs = '0, d_rt = '0, d_wdst = '0;
    logic [1:0]      d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, d_tnew = '0;
    logic            d_wen = 1'b0, ext_stall = 1'b0;
    logic            stall;
    logic [2:0]      fwd_rs, fwd_rt;
    logic [CNTW-1:0] stall_cnt;
    int n_tests = 0;
    int n_fail = 0;
    // In-flight producers, index = stage number (1 = E).
    int m_valid[1:NST];
    int m_wen[1:NST];
    int m_dst[1:NST];
    int m_tnew[1:NST];
    int m_cnt;

    hazard_ctl #(.NSTAGE(NST), .REGW(5), .TW(2), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wen(d_wen),
        .d_wdst(d_wdst), .d_tnew(d_tnew), .ext_stall(ext_stall),
        .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, int got, int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int k = 1; k <= NST; k++) begin
            m_valid[k] = 0; m_wen[k] = 0; m_dst[k] = 0; m_tnew[k] = 0;
        end
        m_cnt = 0;
    endfunction

    function automatic int youngest(int src);
        for (int k = 1; k <= NST; k++)
            if (m_valid[k] != 0 && m_wen[k] != 0 && m_dst[k] == src && src != 0) return k;
        return 0;
    endfunction

    function automatic int need_stall(int src, int tuse);
        int y = youngest(src);
        return (tuse != NONE && y != 0 && m_tnew[y] > tuse) ? 1 : 0;
    endfunction

    function automatic int want_fwd(int src, int tuse);
        int y = youngest(src);
        return (tuse != NONE && y != 0 && m_tnew[y] == 0) ? y : 0;
    endfunction

    task automatic drive(int rs, int trs, int rt, int trt, int wen, int wdst, int tnew, int ext);
        d_rs = 5'(rs); d_tuse_rs = 2'(trs); d_rt = 5'(rt); d_tuse_rt = 2'(trt);
        d_wen = 1'(wen); d_wdst = 5'(wdst); d_tnew = 2'(tnew); ext_stall = 1'(ext);
    endtask

    // Check one Decode cycle, then advance the model across the clock edge.
    task automatic cycle(string tag);
        int es;
        #1;
        es = (need_stall(int'(d_rs), int'(d_tuse_rs)) | need_stall(int'(d_rt), int'(d_tuse_rt)) | int'(ext_stall));
        check({tag, ".stall"}, int'(stall), es);
        check({tag, ".fwd_rs"}, int'(fwd_rs), want_fwd(int'(d_rs), int'(d_tuse_rs)));
        check({tag, ".fwd_rt"}, int'(fwd_rt), want_fwd(int'(d_rt), int'(d_tuse_rt)));
        check({tag, ".cnt"}, int'(stall_cnt), m_cnt);
        @(posedge clk);
        for (int k = NST; k >= 2; k--) begin
            m_valid[k] = m_valid[k-1]; m_wen[k] = m_wen[k-1]; m_dst[k] = m_dst[k-1];
            m_tnew[k] = (m_tnew[k-1] > 0) ? m_tnew[k-1] - 1 : 0;
        end
        m_valid[1] = es ? 0 : 1;
        m_wen[1]   = es ? 0 : int'(d_wen);
        m_dst[1]   = es ? 0 : int'(d_wdst);
        m_tnew[1]  = es ? 0 : int'(d_tnew);
        if (es != 0 && m_cnt < CMAX) m_cnt++;
        @(negedge clk);
    endtask

    task automatic reset_pulse(string tag);
        reset = 1'b1;
        #1;
        check({tag, ".stall"}, int'(stall), int'(ext_stall));
        check({tag, ".fwd_rs"}, int'(fwd_rs), 0);
        check({tag, ".fwd_rt"}, int'(fwd_rt), 0);
        check({tag, ".cnt"}, int'(stall_cnt), 0);
        model_clear();
        reset = 1'b0;
    endtask

    initial begin
        model_clear();
        #2;
        check("rst.stall", int'(stall), 0);
        check("rst.fwd_rs", int'(fwd_rs), 0);
        check("rst.cnt", int'(stall_cnt), 0);
        ext_stall = 1'b1;
        #1;
        check("rst.ext", int'(stall), 1);
        ext_stall = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // load-use: exactly one bubble, then the load has moved on
        drive(0, NONE, 0, NONE, 1, 8, 2, 0);
        cycle("lu.lw");
        drive(8, 1, 0, NONE, 1, 11, 1, 0);
        #1;
        check("lu.stall_first", int'(stall), 1);
        cycle("lu.add1");
        #1;
        check("lu.stall_second", int'(stall), 0);
        cycle("lu.add2");
        drive(8, 0, 11, 0, 0, 0, 0, 0);
        cycle("lu.after");

        // ALU back-to-back and one cycle later
        drive(0, NONE, 0, NONE, 1, 9, 1, 0);
        cycle("alu.ori");
        drive(9, 1, 0, NONE, 0, 0, 0, 0);
        #1;
        check("alu.nostall", int'(stall), 0);
        cycle("alu.use1");
        drive(9, 1, 0, NONE, 0, 0, 0, 0);
        cycle("alu.use2");

        // youngest of two matching producers wins
        drive(0, NONE, 0, NONE, 1, 10, 0, 0);
        cycle("yw.p3");
        drive(0, NONE, 0, NONE, 1, 5, 0, 0);
        cycle("yw.mid");
        drive(0, NONE, 0, NONE, 1, 10, 0, 0);
        cycle("yw.p1");
        drive(0, NONE, 10, 0, 0, 0, 0, 0);
        #1;
        check("yw.fwd_rt", int'(fwd_rt), 1);
        cycle("yw.use");

        // register zero never forwards or stalls
        drive(0, NONE, 0, NONE, 1, 0, 3, 0);
        cycle("z.prod");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("z.stall", int'(stall), 0);
        check("z.fwd_rs", int'(fwd_rs), 0);
        cycle("z.use");

        // async reset while a load-use stall is pending
        drive(0, NONE, 0, NONE, 1, 8, 2, 0);
        cycle("ar.lw");
        drive(8, 1, 0, NONE, 1, 12, 1, 0);
        #1;
        check("ar.pre_stall", int'(stall), 1);
        reset_pulse("ar.rst");
        cycle("ar.post");

        // counter saturation
        drive(0, NONE, 0, NONE, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) cycle("sat");
        #1;
        check("sat.final", int'(stall_cnt), CMAX);
        cycle("sat.hold");

        // randomized traffic with occasional async resets
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? 1 : 0);
            if ($urandom_range(0, 49) == 0) reset_pulse("rnd.rst");
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
